// File: rtl/des_seq_ctrl_if.sv
// des_seq_ctrl_if: M-stage data-bus view of the DES sequencer register window.
interface des_seq_ctrl_if;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        hit;
  modport master (output memwrite, addr, writedata, input readdata, hit);
  modport slave (input memwrite, addr, writedata, output readdata, hit);
endinterface

// File: rtl/des_seq_ctrl.sv
// des_seq_ctrl: memory-mapped sequencer stepping an iterative DES core one round per cycle.
module des_seq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0080,
  parameter int          ROUNDS    = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  des_seq_ctrl_if.slave bus,
  output logic         core_load,
  output logic         core_step,
  output logic [3:0]   core_round,
  output logic         core_mode,
  output logic [63:0]  core_key,
  output logic [63:0]  core_din,
  input  logic [63:0]  core_dout,
  output logic         busy,
  output logic         done
);
  localparam int CW = $clog2(ROUNDS);
  typedef enum logic [1:0] {IDLE, LOAD, ROUND, CAPTURE} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   key_hi, key_lo, data_hi, data_lo, res_hi, res_lo, wd;
  logic [31:0]   rd [8];
  logic [2:0]    sel;
  logic          mode_reg, err, we, ctrl_we, start_ok, bad_wr, last, unused_addr;
  assign wd          = bus.writedata;
  assign sel         = bus.addr[4:2];
  assign unused_addr = ^bus.addr[1:0];
  assign bus.hit     = bus.addr[31:5] == BASE_ADDR[31:5];
  assign we          = bus.memwrite && bus.hit;
  assign ctrl_we     = we && sel == 3'd4;
  assign busy        = state != IDLE;
  assign start_ok    = ctrl_we && wd[0] && !busy;
  // key/data writes or a start while an operation runs are rejected and flagged
  assign bad_wr      = we && busy && (sel < 3'd4 || (sel == 3'd4 && wd[0]));
  assign last        = cnt == CW'(ROUNDS - 1);
  assign core_load   = state == LOAD;
  assign core_step   = state == ROUND;
  assign core_round  = mode_reg ? 4'(cnt) : 4'(ROUNDS - 1) - 4'(cnt);
  assign core_mode   = mode_reg;
  assign core_key    = {key_hi, key_lo};
  assign core_din    = {data_hi, data_lo};
  always_comb begin
    rd[0] = key_hi;
    rd[1] = key_lo;
    rd[2] = data_hi;
    rd[3] = data_lo;
    rd[4] = {30'b0, mode_reg, 1'b0};
    rd[5] = {29'b0, err, done, busy};
    rd[6] = res_hi;
    rd[7] = res_lo;
    bus.readdata = bus.hit ? rd[sel] : '0;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_ok ? LOAD : IDLE;
      LOAD:    state_n = ROUND;
      ROUND:   state_n = last ? CAPTURE : ROUND;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      key_hi   <= '0;
      key_lo   <= '0;
      data_hi  <= '0;
      data_lo  <= '0;
      res_hi   <= '0;
      res_lo   <= '0;
      mode_reg <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state == ROUND && !last) ? cnt + CW'(1) : '0;
      if (we && !busy && sel == 3'd0) key_hi <= wd;
      if (we && !busy && sel == 3'd1) key_lo <= wd;
      if (we && !busy && sel == 3'd2) data_hi <= wd;
      if (we && !busy && sel == 3'd3) data_lo <= wd;
      if (start_ok) mode_reg <= wd[1];
      if (state == CAPTURE) begin
        res_hi <= core_dout[63:32];
        res_lo <= core_dout[31:0];
      end
      // capture and error-setting take priority over their clear bits
      done <= state == CAPTURE || (done && !start_ok && !(ctrl_we && wd[2]));
      err  <= bad_wr || (err && !(ctrl_we && wd[3]));
    end
  end
endmodule

// File: tb/tb_des_seq_ctrl.sv
// tb_des_seq_ctrl: randomized bench with a functional DES core stand-in and full-DES reference.
module tb_des_seq_ctrl;
  localparam logic [31:0] BASE = 32'h0000_0080;
  localparam int ROUNDS = 16;
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  logic clk = 1'b0, reset_n = 1'b0;
  logic core_load, core_step, core_mode, busy, done;
  logic [3:0] core_round;
  logic [63:0] core_key, core_din, core_dout;
  logic [63:0] st = '0, ck = '0;
  int vectors = 0, miscompares = 0;
  int busy_cyc = 0, load_cnt = 0;
  logic [3:0] rounds [$];
  logic [63:0] m_key, m_data, m_res;
  logic m_mode, m_done, m_err;

  des_seq_ctrl_if bus ();
  des_seq_ctrl #(.BASE_ADDR(BASE), .ROUNDS(ROUNDS)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .core_load(core_load), .core_step(core_step), .core_round(core_round), .core_mode(core_mode),
    .core_key(core_key), .core_din(core_din), .core_dout(core_dout), .busy(busy), .done(done));

  always #5 clk = ~clk;

  function automatic logic [63:0] ip(input logic [63:0] x);
    for (int i = 0; i < 64; i++) ip[63-i] = x[64-IP_T[i]];
  endfunction
  function automatic logic [63:0] fp(input logic [63:0] x);
    for (int i = 0; i < 64; i++) fp[63-i] = x[64-FP_T[i]];
  endfunction
  function automatic logic [47:0] subkey(input logic [63:0] key, input int n);
    logic [55:0] cd;
    logic [27:0] c, d;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int j = 0; j <= n; j++)
      for (int s = 0; s < SH_T[j]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    cd = {c, d};
    for (int i = 0; i < 48; i++) subkey[47-i] = cd[56-PC2_T[i]];
  endfunction
  function automatic logic [31:0] feist(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0] b;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x ^= k;
    for (int j = 0; j < 8; j++) begin
      b = x[47-6*j -: 6];
      s[31-4*j -: 4] = 4'(SB[j][int'({b[5], b[0]}) * 16 + int'(b[4:1])]);
    end
    for (int i = 0; i < 32; i++) feist[31-i] = s[32-P_T[i]];
  endfunction
  function automatic logic [63:0] des(input logic [63:0] key, input logic [63:0] data, input logic enc);
    logic [63:0] t;
    logic [31:0] l, r, nl;
    t = ip(data);
    l = t[63:32];
    r = t[31:0];
    for (int i = 0; i < 16; i++) begin
      nl = r;
      r = l ^ feist(r, subkey(key, enc ? i : 15 - i));
      l = nl;
    end
    des = fp({r, l});
  endfunction

  // behavioural stand-in for the iterative core the controller drives
  always @(posedge clk)
    if (core_load) begin
      st <= ip(core_din);
      ck <= core_key;
    end else if (core_step)
      st <= {st[31:0], st[63:32] ^ feist(st[31:0], subkey(ck, int'(core_round)))};
  assign core_dout = fp({st[31:0], st[63:32]});

  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (core_load) load_cnt++;
    if (core_step) rounds.push_back(core_round);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wr(input int off, input logic [31:0] d);
    @(negedge clk);
    bus.memwrite = 1'b1;
    bus.addr = BASE + 32'(off);
    bus.writedata = d;
    @(negedge clk);
    bus.memwrite = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    @(negedge clk);
    bus.addr = a;
    #1;
    d = bus.readdata;
    h = bus.hit;
  endtask
  task automatic chk_rd(input string tag, input int off, input logic [31:0] exp);
    logic [31:0] d;
    logic h;
    rd(BASE + 32'(off), d, h);
    check(tag, d, exp);
  endtask
  task automatic load(input logic [63:0] key, input logic [63:0] data);
    wr('h00, key[63:32]);
    wr('h04, key[31:0]);
    wr('h08, data[63:32]);
    wr('h0c, data[31:0]);
    m_key = key;
    m_data = data;
  endtask
  task automatic start_op(input logic mode, input logic clr);
    busy_cyc = 0;
    load_cnt = 0;
    rounds.delete();
    wr('h10, {29'b0, clr, mode, 1'b1});
    m_mode = mode;
    m_done = 1'b0;
  endtask
  task automatic finish_op();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
    check("busy_cycles", busy_cyc, ROUNDS + 2);
    check("load_pulses", load_cnt, 1);
    check("round_count", rounds.size(), ROUNDS);
    for (int i = 0; i < ROUNDS; i++)
      check("round_idx", (i < rounds.size()) ? rounds[i] : 4'hx, m_mode ? i : ROUNDS - 1 - i);
    m_res = des(m_key, m_data, m_mode);
    m_done = 1'b1;
    chk_rd("reshi", 'h18, m_res[63:32]);
    chk_rd("reslo", 'h1c, m_res[31:0]);
    chk_rd("status_done", 'h14, {29'b0, m_err, m_done, 1'b0});
  endtask

  initial begin
    logic [31:0] d;
    logic h;
    int n;
    logic md;
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic h;
    int n;
    logic md;
    bus.memwrite = 1'b0;
    bus.addr = '0;
    bus.writedata = '0;
    m_key = '0; m_data = '0; m_res = '0; m_mode = 1'b0; m_done = 1'b0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load_step", {core_load, core_step}, 0);
    for (int i = 0; i < 8; i++) begin
      rd(BASE + 32'(4 * i), d, h);
      check("rst_read", d, 0);
      check("rst_hit", h, 1);
    end
    rd(BASE + 32'h20, d, h);
    check("above_hit", h, 0);
    check("above_data", d, 0);
    rd(BASE - 32'h4, d, h);
    check("below_hit", h, 0);

    load(64'h1334_5779_9BBC_DFF1, 64'h0123_4567_89AB_CDEF);
    rd(BASE + 32'h07, d, h);
    check("byte_lanes_ignored", d, 32'h9BBC_DFF1);
    check("core_key", core_key, m_key);
    start_op(1'b1, 1'b0);
    check("core_mode_enc", core_mode, 1);
    finish_op();
    check("kat_enc", m_res, 64'h85E8_1354_0F0A_B405);
    chk_rd("ctrl_enc", 'h10, 32'h2);

    load(64'h1334_5779_9BBC_DFF1, 64'h85E8_1354_0F0A_B405);
    start_op(1'b0, 1'b0);
    finish_op();
    check("kat_dec", m_res, 64'h0123_4567_89AB_CDEF);
    chk_rd("ctrl_dec", 'h10, 32'h0);

    start_op(1'b1, 1'b0);
    wr('h04, 32'hFFFF_FFFF);
    m_err = 1'b1;
    wr('h10, 32'h1);
    chk_rd("status_err_busy", 'h14, 32'h5);
    wr('h10, 32'h9);
    chk_rd("err_set_wins", 'h14, 32'h5);
    finish_op();
    chk_rd("keylo_kept", 'h04, m_key[31:0]);
    wr('h10, 32'hC);
    m_err = 1'b0;
    m_done = 1'b0;
    chk_rd("status_cleared", 'h14, 32'h0);

    start_op(1'b1, 1'b0);
    n = 0;
    while (rounds.size() < 7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("step_before_reset", core_step, 1);
    reset_n = 1'b0;
    #1;
    check("async_step_drop", core_step, 0);
    check("async_busy_drop", busy, 0);
    #2;
    reset_n = 1'b1;
    m_key = '0; m_data = '0; m_res = '0; m_mode = 1'b0; m_done = 1'b0; m_err = 1'b0;
    chk_rd("status_after_rst", 'h14, 32'h0);
    chk_rd("reshi_after_rst", 'h18, 32'h0);
    chk_rd("reslo_after_rst", 'h1c, 32'h0);
    chk_rd("keyhi_after_rst", 'h00, 32'h0);
    load({$urandom, $urandom}, {$urandom, $urandom});
    start_op(1'b1, 1'b0);
    finish_op();

    load(m_key, {$urandom, $urandom});
    start_op(1'b1, 1'b1);
    chk_rd("status_restart", 'h14, 32'h1);
    chk_rd("reshi_held", 'h18, m_res[63:32]);
    chk_rd("reslo_held", 'h1c, m_res[31:0]);
    finish_op();

    for (int k = 0; k < 6; k++) begin
      md = 1'($urandom_range(0, 1));
      load({$urandom, $urandom}, {$urandom, $urandom});
      chk_rd("rand_keyhi", 'h00, m_key[63:32]);
      chk_rd("rand_keylo", 'h04, m_key[31:0]);
      chk_rd("rand_datahi", 'h08, m_data[63:32]);
      chk_rd("rand_datalo", 'h0c, m_data[31:0]);
      check("rand_core_din", core_din, m_data);
      start_op(md, 1'($urandom_range(0, 1)));
      chk_rd("rand_status_busy", 'h14, 32'h1);
      finish_op();
      chk_rd("rand_ctrl", 'h10, {30'b0, md, 1'b0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/des_seq_ctrl.md
Name: des_seq_ctrl

Overview:
Memory-mapped controller that sequences an iterative, one-round-per-cycle DES core behind the MIPS pipeline's M-stage data bus. It holds key, data, control, status and result registers in a 32-byte address window. On a START write it loads the core and steps it through ROUNDS rounds, with the subkey order chosen by mode. It then captures the 64-bit result and flags done for software polling.

Parameters:
BASE_ADDR, 32'h0000_0080, byte base of the 32-byte register window; must be 32-byte aligned
ROUNDS, 16, number of core rounds per operation (2..16)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
memwrite  in  1  store in M stage
addr  in  32  M-stage byte address (aluout)
writedata  in  32  M-stage store data
readdata  out  32  combinational read data for the addressed register
hit  out  1  addr falls in the window; top-level read mux selects readdata when high
core_load  out  1  one-cycle pulse: core latches core_key/core_din and applies the initial permutation
core_step  out  1  core executes one round this cycle
core_round  out  4  round index driving subkey selection
core_mode  out  1  1 = encrypt, 0 = decrypt; latched at start
core_key  out  64  {KEYHI, KEYLO}
core_din  out  64  {DATAHI, DATALO}
core_dout  in  64  core output after the final permutation; valid in the cycle after the last step
busy  out  1  operation in progress
done  out  1  sticky result-valid flag

Behaviour:
- Register map (byte offset): 0x00 KEYHI RW, 0x04 KEYLO RW, 0x08 DATAHI RW, 0x0C DATALO RW, 0x10 CTRL, 0x14 STATUS RO, 0x18 RESHI RO, 0x1C RESLO RO.
- hit = (addr[31:5] == BASE_ADDR[31:5]); the register is selected by addr[4:2]; addr[1:0] is ignored.
- A write takes effect on the clk edge where memwrite and hit are both high.
- Writes to RO registers are ignored.
- readdata is combinational with no read side effects; it is 0 when hit is low.
- CTRL write bits: [0] start, [1] mode, [2] clr_done, [3] clr_err. A CTRL read returns {30'b0, mode_reg, 1'b0}.
- STATUS read: {29'b0, err, done, busy}.
- Reset: all registers 0, state IDLE, and every output 0 (readdata 0, or the zeroed register when hit).
- FSM states:
  - IDLE: a start write moves to LOAD on that edge; mode_reg <= writedata[1], busy <= 1, done <= 0.
  - LOAD: core_load = 1 for exactly one cycle, then ROUND with cnt = 0.
  - ROUND: core_step = 1; core_round = cnt when encrypting, ROUNDS-1-cnt when decrypting; cnt increments each cycle; after the cycle with cnt = ROUNDS-1, go to CAPTURE.
  - CAPTURE: RESHI/RESLO <= core_dout; done <= 1, busy <= 0; go to IDLE.
- Latency: start sampled at edge t; busy visible after t; core_load active in cycle t..t+1; done = 1 and the result readable after edge t+ROUNDS+2 (t+18 with default ROUNDS).
- core_mode = mode_reg at all times.
- core_key and core_din are driven straight from the registers.
- Busy protection: while busy, writes to KEY*/DATA* and start are ignored and set err (sticky). clr_done and clr_err writes are still honoured while busy.
- Simultaneous events:
  - start + clr_done in the same write in IDLE: operation starts and done = 0.
  - clr_err + an illegal write on the same edge: err = 1, because set wins.
  - A completed result stays in RESHI/RESLO until the next CAPTURE or reset.
  - done = 1 in IDLE does not block a new start.
- Reset mid-operation: immediate return to IDLE; busy, done, err and the result registers are 0; core_load and core_step drop asynchronously.
- cnt is wide enough for ROUNDS-1 and never wraps past ROUNDS-1.

Test Plan:
- Reset, then read all 8 offsets -> readdata 0 and hit = 1. Read BASE_ADDR+0x20 -> hit = 0, readdata 0.
- Write KEY 0x133457799BBCDFF1 and DATA 0x0123456789ABCDEF, then CTRL = 0x3 against a reference iterative DES model:
  - busy = 1 for exactly 18 cycles.
  - core_round runs 0..15.
  - RESHI:RESLO = 0x85E81354:0x0F0AB405, STATUS = 0x2.
- Load DATA = 0x85E813540F0AB405, then CTRL = 0x1 (decrypt) -> core_round runs 15..0 and the result is 0x0123456789ABCDEF.
- During busy, write KEYLO = 0xFFFFFFFF and CTRL = 0x1 -> KEYLO is unchanged, there is no restart, STATUS = 0x5. After completion, CTRL = 0xC -> STATUS = 0x0.
- Start, then pulse reset_n low at cycle 7 of ROUND -> core_step drops immediately; STATUS = 0 and RES = 0 after release; a new start runs the full 18 cycles.
- With done = 1, write CTRL = 0x7 -> done clears on the same edge, a new operation starts, and the previous RES value is held until the new CAPTURE.
